// File: rtl/lsu.sv
// -----------------------------------------------------------------------------
// lsu - execute-stage load/store unit.
//
// Accepts one decoded load or store per ex_valid while idle, runs it on the
// data-memory bus with a req/ack handshake and returns a single-cycle ls_done
// that releases the fetcher. Loads return lane-selected, sign/zero-extended
// data with a write-back strobe.
//
// Ports
//   clk, rstb                 clock, asynchronous active-low reset
//   ex_valid                  decoded instruction valid
//   op_load, op_store         opcode class (load has priority if both set)
//   funct3                    access size/sign
//   base, offset              rs1 value and signed immediate; ea = base+offset
//   wdata_in                  rs2 value (stores)
//   dest                      rd index (loads)
//   ls_done, ls_err           completion pulse and fault flag
//   wb_en, wb_rd, wb_data     register write-back, coincident with ls_done
//   d_req, d_we, d_addr,
//   d_wdata, d_be             data-memory request, held stable until d_ack
//   d_ack, d_rdata            data-memory acknowledge and read data
//
// Parameters
//   TIMEOUT_CYC               max d_req cycles without d_ack; 0 disables
//
// Build options
//   LSU_MISALIGN_CHK_EN       when defined, misaligned half/word accesses
//                             complete as errors without a bus request;
//                             otherwise they proceed aligned down.
// -----------------------------------------------------------------------------
module lsu #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic        clk,
  input  logic        rstb,
  input  logic        ex_valid,
  input  logic        op_load,
  input  logic        op_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] base,
  input  logic [31:0] offset,
  input  logic [31:0] wdata_in,
  input  logic [4:0]  dest,
  output logic        ls_done,
  output logic        ls_err,
  output logic        wb_en,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        d_req,
  output logic        d_we,
  output logic [31:0] d_addr,
  output logic [31:0] d_wdata,
  output logic [3:0]  d_be,
  input  logic        d_ack,
  input  logic [31:0] d_rdata
);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT_CYC > 0) ? CW'(TIMEOUT_CYC - 1) : '0;

  // Sign/zero extension of the addressed lane of the returned word.
  function automatic logic [31:0] load_extend(input logic [2:0]  f3,
                                              input logic [1:0]  lo,
                                              input logic [31:0] rd);
    logic signed [7:0]  b_s;
    logic signed [15:0] h_s;
    logic [31:0]        res;
    b_s = rd[{lo, 3'b000} +: 8];
    h_s = lo[1] ? rd[31:16] : rd[15:0];
    case (f3)
      3'b000:  res = 32'(b_s);
      3'b001:  res = 32'(h_s);
      3'b100:  res = {24'h0, b_s};
      3'b101:  res = {16'h0, h_s};
      default: res = rd;
    endcase
    return res;
  endfunction

  function automatic logic [3:0] lane_be(input logic [1:0] sz, input logic [1:0] lo);
    logic [3:0] be;
    case (sz)
      2'b00:   be = 4'b0001 << lo;
      2'b01:   be = lo[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [1:0] sz, input logic [31:0] wd);
    logic [31:0] w;
    case (sz)
      2'b00:   w = {4{wd[7:0]}};
      2'b01:   w = {2{wd[15:0]}};
      default: w = wd;
    endcase
    return w;
  endfunction

  function automatic logic illegal_f3(input logic is_load, input logic [2:0] f3);
    logic bad;
    if (is_load) bad = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    else         bad = (f3 > 3'b010);
    return bad;
  endfunction

  // Registered state and outputs
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ls_done_q, ls_done_d;
  logic          ls_err_q, ls_err_d;
  logic          wb_en_q, wb_en_d;
  logic [4:0]    wb_rd_q, wb_rd_d;
  logic [31:0]   wb_data_q, wb_data_d;
  logic          d_req_q, d_req_d;
  logic          d_we_q, d_we_d;
  logic [31:0]   d_addr_q, d_addr_d;
  logic [31:0]   d_wdata_q, d_wdata_d;
  logic [3:0]    d_be_q, d_be_d;

  // Latched request attributes (data only, not reset)
  logic          load_q, load_d;
  logic [2:0]    f3_q, f3_d;
  logic [4:0]    dest_q, dest_d;
  logic [1:0]    ea_lo_q, ea_lo_d;

  logic [31:0]   ea;
  logic          misalign;
  logic          reject;
  logic          to_hit;

  // Offset is a two's-complement immediate; the 32-bit add wraps mod 2^32.
  assign ea = base + offset;

`ifdef LSU_MISALIGN_CHK_EN
  assign misalign = ((funct3[1:0] == 2'b01) && ea[0]) ||
                    ((funct3[1:0] == 2'b10) && (ea[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign reject = illegal_f3(op_load, funct3) || misalign;
  // An ack on the final allowed cycle takes priority (checked first below).
  assign to_hit = (TIMEOUT_CYC != 0) && (cnt_q == CNT_LAST);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ls_done_d = 1'b0;
    ls_err_d  = 1'b0;
    wb_en_d   = 1'b0;
    wb_rd_d   = 5'd0;
    wb_data_d = 32'd0;
    d_req_d   = d_req_q;
    d_we_d    = d_we_q;
    d_addr_d  = d_addr_q;
    d_wdata_d = d_wdata_q;
    d_be_d    = d_be_q;
    load_d    = load_q;
    f3_d      = f3_q;
    dest_d    = dest_q;
    ea_lo_d   = ea_lo_q;

    case (state_q)
      IDLE: begin
        if (ex_valid && (op_load || op_store)) begin
          load_d  = op_load;
          f3_d    = funct3;
          dest_d  = dest;
          ea_lo_d = ea[1:0];
          if (reject) begin
            state_d   = RESP;
            ls_done_d = 1'b1;
            ls_err_d  = 1'b1;
            wb_rd_d   = dest;
          end else begin
            state_d   = BUS;
            cnt_d     = '0;
            d_req_d   = 1'b1;
            d_we_d    = ~op_load;
            d_addr_d  = {ea[31:2], 2'b00};
            d_be_d    = lane_be(funct3[1:0], ea[1:0]);
            d_wdata_d = lane_wdata(funct3[1:0], wdata_in);
          end
        end
      end

      BUS: begin
        if (d_ack || to_hit) begin
          state_d   = RESP;
          d_req_d   = 1'b0;
          d_we_d    = 1'b0;
          d_be_d    = 4'b0000;
          ls_done_d = 1'b1;
          wb_rd_d   = dest_q;
          if (d_ack) begin
            if (load_q) begin
              wb_en_d   = (dest_q != 5'd0);
              wb_data_d = load_extend(f3_q, ea_lo_q, d_rdata);
            end
          end else begin
            ls_err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control and output registers
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ls_done_q <= 1'b0;
      ls_err_q  <= 1'b0;
      wb_en_q   <= 1'b0;
      wb_rd_q   <= 5'd0;
      wb_data_q <= 32'd0;
      d_req_q   <= 1'b0;
      d_we_q    <= 1'b0;
      d_addr_q  <= 32'd0;
      d_wdata_q <= 32'd0;
      d_be_q    <= 4'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ls_done_q <= ls_done_d;
      ls_err_q  <= ls_err_d;
      wb_en_q   <= wb_en_d;
      wb_rd_q   <= wb_rd_d;
      wb_data_q <= wb_data_d;
      d_req_q   <= d_req_d;
      d_we_q    <= d_we_d;
      d_addr_q  <= d_addr_d;
      d_wdata_q <= d_wdata_d;
      d_be_q    <= d_be_d;
    end
  end

  // Request attribute registers
  always_ff @(posedge clk) begin
    load_q  <= load_d;
    f3_q    <= f3_d;
    dest_q  <= dest_d;
    ea_lo_q <= ea_lo_d;
  end

  assign ls_done = ls_done_q;
  assign ls_err  = ls_err_q;
  assign wb_en   = wb_en_q;
  assign wb_rd   = wb_rd_q;
  assign wb_data = wb_data_q;
  assign d_req   = d_req_q;
  assign d_we    = d_we_q;
  assign d_addr  = d_addr_q;
  assign d_wdata = d_wdata_q;
  assign d_be    = d_be_q;

endmodule

// File: tb/tb_lsu.sv
module tb_lsu;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rstb = 1'b0;
  logic        ex_valid = 1'b0, op_load = 1'b0, op_store = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] base = 32'd0, offset = 32'd0, wdata_in = 32'd0;
  logic [4:0]  dest = 5'd0;
  logic        ls_done, ls_err, wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        d_req, d_we;
  logic [31:0] d_addr, d_wdata;
  logic [3:0]  d_be;
  logic        d_ack = 1'b0;
  logic [31:0] d_rdata = 32'd0;

  lsu #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rstb(rstb), .ex_valid(ex_valid), .op_load(op_load), .op_store(op_store),
    .funct3(funct3), .base(base), .offset(offset), .wdata_in(wdata_in), .dest(dest),
    .ls_done(ls_done), .ls_err(ls_err), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_ack(d_ack), .d_rdata(d_rdata)
  );

  always #5 clk = ~clk;

  // One expected output snapshot per clock cycle.
  typedef struct packed {
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        done;
    logic        err;
    logic        wben;
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0, n_pass = 0;
  bit   chk_en = 1'b0;

  // Observations captured by the compare process, used by the literal checks.
  int          req_cnt = 0, done_cnt = 0;
  logic [31:0] cap_addr, cap_wdata, cap_data;
  logic [3:0]  cap_be;
  logic        cap_we, cap_err, cap_wben;
  logic [4:0]  cap_rd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (chk_en) begin
      e = '0;
      if (q.size() > 0) e = q.pop_front();
      check("d_req", 32'(d_req), 32'(e.req));
      check("ls_done", 32'(ls_done), 32'(e.done));
      check("wb_en", 32'(wb_en), 32'(e.wben));
      if (e.req) begin
        check("d_we", 32'(d_we), 32'(e.we));
        check("d_addr", d_addr, e.addr);
        check("d_be", 32'(d_be), 32'(e.be));
        if (e.we) check("d_wdata", d_wdata, e.wdata);
      end
      if (e.done) begin
        check("ls_err", 32'(ls_err), 32'(e.err));
        check("wb_data", wb_data, e.data);
        if (e.wben) check("wb_rd", 32'(wb_rd), 32'(e.rd));
      end
    end
    if (d_req) begin
      req_cnt++;
      cap_addr = d_addr; cap_be = d_be; cap_we = d_we; cap_wdata = d_wdata;
    end
    if (ls_done) begin
      done_cnt++;
      cap_err = ls_err; cap_wben = wb_en; cap_rd = wb_rd; cap_data = wb_data;
    end
  end

  // Issue one access. nreq: d_req cycles until ack (ack in the nreq-th cycle);
  // ack=0 leaves the bus silent; abort_at>0 pulls reset in that d_req cycle.
  task automatic run(input bit ld, input logic [2:0] f3, input logic [31:0] b,
                     input logic [31:0] off, input logic [31:0] wd, input logic [4:0] rd,
                     input int nreq, input bit ack, input logic [31:0] rdat, input int abort_at);
    logic [31:0] ea, shifted, mask, val;
    bit          bad;
    int          bytes, first, n;
    exp_t        e;
    ea    = b + off;
    bytes = 1 << f3[1:0];
    bad   = ld ? (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) : (f3 > 3'b010);
`ifdef LSU_MISALIGN_CHK_EN
    if (ea % bytes != 0) bad = 1'b1;
`endif
    first   = 32'(ea[1:0]) & ~(bytes - 1);
    shifted = rdat >> (8 * first);
    mask    = (bytes == 4) ? 32'hFFFF_FFFF : (32'h1 << (8 * bytes)) - 32'h1;
    val     = shifted & mask;
    if (!f3[2] && bytes < 4 && val[8*bytes-1]) val = val | ~mask;

    e = '0;
    q.push_back(e);                      // acceptance cycle: nothing visible yet
    n = bad ? 0 : (ack ? nreq : TO);
    for (int i = 0; i < n; i++) begin
      e = '0;
      e.req   = 1'b1;
      e.we    = ~ld;
      e.addr  = ea & ~32'h3;
      e.be    = 4'(((1 << bytes) - 1) << first);
      e.wdata = (bytes == 1) ? {24'h0, wd[7:0]} * 32'h0101_0101 :
                (bytes == 2) ? {16'h0, wd[15:0]} * 32'h0001_0001 : wd;
      q.push_back(e);
    end
    e = '0;
    e.done = 1'b1;
    e.err  = bad || !ack;
    e.wben = ld && !e.err && (rd != 0);
    e.rd   = rd;
    e.data = (ld && !e.err) ? val : 32'h0;
    q.push_back(e);

    ex_valid = 1'b1; op_load = ld; op_store = ~ld; funct3 = f3;
    base = b; offset = off; wdata_in = wd; dest = rd;
    @(posedge clk); #1;
    ex_valid = 1'b0; op_load = 1'b0; op_store = 1'b0;
    for (int i = 1; i <= n; i++) begin
      d_ack   = ack && (i == nreq);
      d_rdata = d_ack ? rdat : $urandom;
      if (i == abort_at) begin
        d_ack = 1'b0;
        rstb  = 1'b0;
        q.delete();
        #1;
        check("rst_drops_req", 32'(d_req), 32'h0);
        @(posedge clk); #1;
        rstb = 1'b1;
        return;
      end
      @(posedge clk); #1;
    end
    d_ack = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    int r0, d0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_d_req", 32'(d_req), 32'h0);
    check("rst_ls_done", 32'(ls_done), 32'h0);
    check("rst_wb_en", 32'(wb_en), 32'h0);
    check("rst_d_be", 32'(d_be), 32'h0);
    check("rst_wb_data", wb_data, 32'h0);
    rstb = 1'b1;
    @(posedge clk); #1;
    chk_en = 1'b1;

    // LW, ack in the third d_req cycle
    r0 = req_cnt;
    run(1, 3'b010, 32'h100, 32'd4, 32'h0, 5'd5, 3, 1, 32'hDEAD_BEEF, 0);
    check("lw_req_cycles", 32'(req_cnt - r0), 32'd3);
    check("lw_addr", cap_addr, 32'h104);
    check("lw_be", 32'(cap_be), 32'hF);
    check("lw_data", cap_data, 32'hDEAD_BEEF);
    check("lw_rd", 32'(cap_rd), 32'd5);
    check("lw_wben", 32'(cap_wben), 32'h1);

    // LB / LBU at ea=0x203
    run(1, 3'b000, 32'h200, 32'd3, 32'h0, 5'd7, 1, 1, 32'h8012_3456, 0);
    check("lb_be", 32'(cap_be), 32'h8);
    check("lb_data", cap_data, 32'hFFFF_FF80);
    run(1, 3'b100, 32'h200, 32'd3, 32'h0, 5'd7, 2, 1, 32'h8012_3456, 0);
    check("lbu_data", cap_data, 32'h0000_0080);

    // LH / LHU upper half, LH lower half positive
    run(1, 3'b001, 32'h600, 32'd2, 32'h0, 5'd8, 1, 1, 32'h8001_7FFF, 0);
    check("lh_data", cap_data, 32'hFFFF_8001);
    run(1, 3'b101, 32'h600, 32'd2, 32'h0, 5'd8, 1, 1, 32'h8001_7FFF, 0);
    check("lhu_data", cap_data, 32'h0000_8001);
    run(1, 3'b001, 32'h600, 32'd0, 32'h0, 5'd8, 2, 1, 32'h8001_7FFF, 0);

    // SH at ea=0x302 via a negative offset, zero-wait ack
    run(0, 3'b001, 32'h310, 32'hFFFF_FFF2, 32'h1234_ABCD, 5'd0, 1, 1, 32'h0, 0);
    check("sh_we", 32'(cap_we), 32'h1);
    check("sh_be", 32'(cap_be), 32'hC);
    check("sh_wdata", cap_wdata, 32'hABCD_ABCD);
    check("sh_wben", 32'(cap_wben), 32'h0);

    // SB at ea=0x701, SW
    run(0, 3'b000, 32'h700, 32'd1, 32'h0000_005A, 5'd0, 2, 1, 32'h0, 0);
    check("sb_wdata", cap_wdata, 32'h5A5A_5A5A);
    run(0, 3'b010, 32'h800, 32'd0, 32'h0BAD_F00D, 5'd0, 1, 1, 32'h0, 0);

    // Misaligned LW at ea=0x401
    r0 = req_cnt;
    run(1, 3'b010, 32'h400, 32'd1, 32'h0, 5'd3, 2, 1, 32'h1122_3344, 0);
`ifdef LSU_MISALIGN_CHK_EN
    check("mis_no_req", 32'(req_cnt - r0), 32'd0);
    check("mis_err", 32'(cap_err), 32'h1);
`else
    check("mis_addr", cap_addr, 32'h400);
    check("mis_be", 32'(cap_be), 32'hF);
    check("mis_data", cap_data, 32'h1122_3344);
`endif

    // Illegal funct3: load 011, store 100
    run(1, 3'b011, 32'h900, 32'd0, 32'h0, 5'd4, 1, 1, 32'h0, 0);
    check("ill_ld_err", 32'(cap_err), 32'h1);
    run(0, 3'b100, 32'h900, 32'd0, 32'h0, 5'd0, 1, 1, 32'h0, 0);

    // Timeout, then ack on the expiry cycle
    r0 = req_cnt;
    run(1, 3'b010, 32'hA00, 32'd0, 32'h0, 5'd6, 0, 0, 32'h0, 0);
    check("to_req_cycles", 32'(req_cnt - r0), 32'd16);
    check("to_err", 32'(cap_err), 32'h1);
    check("to_wben", 32'(cap_wben), 32'h0);
    r0 = req_cnt;
    run(1, 3'b010, 32'hA00, 32'd0, 32'h0, 5'd6, 16, 1, 32'h5555_AAAA, 0);
    check("ack16_req_cycles", 32'(req_cnt - r0), 32'd16);
    check("ack16_err", 32'(cap_err), 32'h0);

    // Reset mid-transfer, then a normal LW
    d0 = done_cnt;
    run(1, 3'b010, 32'hB00, 32'd0, 32'h0, 5'd2, 5, 1, 32'h0, 3);
    repeat (2) @(posedge clk);
    #1;
    check("rst_no_done", 32'(done_cnt - d0), 32'd0);
    run(1, 3'b010, 32'h500, 32'd8, 32'h0, 5'd9, 2, 1, 32'hCAFE_F00D, 0);
    check("post_rst_data", cap_data, 32'hCAFE_F00D);

    // LB to x0
    d0 = done_cnt;
    run(1, 3'b000, 32'hC00, 32'd0, 32'h0, 5'd0, 1, 1, 32'h0000_00FF, 0);
    check("x0_done", 32'(done_cnt - d0), 32'd1);
    check("x0_wben", 32'(cap_wben), 32'h0);

    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
